paddsb_accum: RTL and testbench



---
 rtl/paddsb_accum_if.sv | 24 ++
 rtl/paddsb_accum.sv | 109 ++++++++++
 tb/tb_paddsb_accum.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/paddsb_accum_if.sv
// Handshake bundle for paddsb_accum: start/count launch, beat input stream, result output.
// The master drives stimulus and consumes results; the slave is the accumulator.
interface paddsb_accum_if;
  logic        start;
  logic [3:0]  count;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_error;
  logic        busy;

  modport master (
    output start, count, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_error, busy
  );

  modport slave (
    input  start, count, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_error, busy
  );
endinterface

// File: rtl/paddsb_accum.sv
// Sequenced 4x4-bit lane accumulator for the PADDSB reduction path.
// Define PADDSB_ACC_SAT_EN for per-lane signed saturation; otherwise lanes wrap.
//
// state  | meaning
// IDLE   | waiting for start; result of last run no longer offered
// ACC    | accepting beats until the programmed count is consumed
// DONE   | result presented, held until the consumer takes it
module paddsb_accum (
  input  logic           i_clk,
  input  logic           i_rst,
  paddsb_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_acc;
  logic [15:0] w_acc_nxt;
  logic        r_err;
  logic        w_err_nxt;
  logic [3:0]  r_remaining;
  logic [3:0]  w_remaining_nxt;

  logic [15:0] w_lane_sum;
  logic [3:0]  w_lane_ovf;
  logic        w_beat;

  // Lanes are independent 4-bit adders; no carry crosses a lane boundary.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [3:0] w_a;
    logic [3:0] w_b;
    logic [3:0] w_mod;

    assign w_a           = r_acc[4*k +: 4];
    assign w_b           = bus.in_data[4*k +: 4];
    assign w_mod         = w_a + w_b;
    assign w_lane_ovf[k] = (w_a[3] == w_b[3]) && (w_mod[3] != w_a[3]);

`ifdef PADDSB_ACC_SAT_EN
    assign w_lane_sum[4*k +: 4] = w_lane_ovf[k] ? (w_a[3] ? 4'h8 : 4'h7) : w_mod;
`else
    assign w_lane_sum[4*k +: 4] = w_mod;
`endif
  end

  assign w_beat = (r_state == S_ACC) && bus.in_valid;

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_err_nxt       = r_err;
    w_remaining_nxt = r_remaining;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_acc_nxt       = 16'h0000;
          w_err_nxt       = 1'b0;
          w_remaining_nxt = bus.count;
          w_state_nxt     = (bus.count != 4'd0) ? S_ACC : S_DONE;
        end
      end
      S_ACC: begin
        if (w_beat) begin
          w_acc_nxt       = w_lane_sum;
          w_err_nxt       = r_err | (|w_lane_ovf);
          w_remaining_nxt = r_remaining - 4'd1;
          if (r_remaining == 4'd1) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // start is deliberately ignored here, even in the accept cycle.
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_acc       <= 16'h0000;
      r_err       <= 1'b0;
      r_remaining <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_err       <= w_err_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  assign bus.in_ready  = (r_state == S_ACC);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_sum   = r_acc;
  assign bus.out_error = r_err;

endmodule

// File: tb/tb_paddsb_accum.sv
// Randomized and directed bench for paddsb_accum against an integer-arithmetic lane model.
// Expected values follow PADDSB_ACC_SAT_EN the same way the design does.
module tb_paddsb_accum;

  logic i_clk;
  logic i_rst;
  paddsb_accum_if bus ();

  paddsb_accum dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] beats [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {err, sum} for the first n entries of beats[].
  function automatic logic [16:0] model(input int n);
    int          lane [4];
    logic        err;
    logic [15:0] sum;
    for (int k = 0; k < 4; k++) lane[k] = 0;
    err = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        int b;
        int s;
        b = int'((beats[i] >> (4 * k)) & 16'h000F);
        if (b > 7) b -= 16;
        s = lane[k] + b;
        if (s > 7 || s < -8) begin
          err = 1'b1;
`ifdef PADDSB_ACC_SAT_EN
          s = (s > 7) ? 7 : -8;
`else
          s = (s > 7) ? s - 16 : s + 16;
`endif
        end
        lane[k] = s;
      end
    end
    sum = 16'h0000;
    for (int k = 0; k < 4; k++) sum = sum | (16'(lane[k] & 15) << (4 * k));
    return {err, sum};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_acc(input string tag, input logic [3:0] n, input int gap_pct,
                         input int hold, input logic [16:0] exp);
    bus.start = 1'b1;
    bus.count = n;
    tick();
    bus.start = 1'b0;
    bus.count = 4'($urandom);
    check({tag, ".busy_after_start"}, bus.busy, 1);
    check({tag, ".in_ready_after_start"}, bus.in_ready, n != 4'd0);
    for (int i = 0; i < int'(n); i++) begin
      for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        tick();
        check({tag, ".in_ready_gap"}, bus.in_ready, 1);
      end
      check({tag, ".in_ready_beat"}, bus.in_ready, 1);
      check({tag, ".out_valid_early"}, bus.out_valid, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = beats[i];
      tick();
      bus.in_valid = 1'b0;
    end
    check({tag, ".out_valid"}, bus.out_valid, 1);
    check({tag, ".out_sum"}, bus.out_sum, exp[15:0]);
    check({tag, ".out_error"}, bus.out_error, exp[16]);
    check({tag, ".in_ready_done"}, bus.in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      bus.start    = 1'($urandom);
      bus.in_valid = 1'($urandom);
      bus.in_data  = 16'($urandom);
      tick();
      check({tag, ".hold_valid"}, bus.out_valid, 1);
      check({tag, ".hold_sum"}, {bus.out_error, bus.out_sum}, exp);
      check({tag, ".hold_in_ready"}, bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.start     = 1'b1;
    bus.count     = 4'd5;
    bus.out_ready = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    check({tag, ".busy_after_accept"}, bus.busy, 0);
    check({tag, ".out_valid_after_accept"}, bus.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [16:0] exp;
    bus.start     = 1'b0;
    bus.count     = 4'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b0;
    i_rst         = 1'b1;
    tick();
    tick();
    check("reset.in_ready", bus.in_ready, 0);
    check("reset.out_valid", bus.out_valid, 0);
    check("reset.out_sum", bus.out_sum, 16'h0000);
    check("reset.out_error", bus.out_error, 0);
    check("reset.busy", bus.busy, 0);
    i_rst = 1'b0;
    tick();

    beats[0] = 16'h1234; beats[1] = 16'h1111;
    run_acc("basic", 4'd2, 0, 0, {1'b0, 16'h2345});

    beats[0] = 16'h4444; beats[1] = 16'h4444;
`ifdef PADDSB_ACC_SAT_EN
    run_acc("pos_ovf", 4'd2, 0, 1, {1'b1, 16'h7777});
`else
    run_acc("pos_ovf", 4'd2, 0, 1, {1'b1, 16'h8888});
`endif

    beats[0] = 16'h8888; beats[1] = 16'h8888;
`ifdef PADDSB_ACC_SAT_EN
    run_acc("neg_ovf", 4'd2, 0, 0, {1'b1, 16'h8888});
`else
    run_acc("neg_ovf", 4'd2, 0, 0, {1'b1, 16'h0000});
`endif

    beats[0] = 16'h0007; beats[1] = 16'h0001; beats[2] = 16'h00F9;
`ifdef PADDSB_ACC_SAT_EN
    run_acc("sticky", 4'd3, 0, 0, {1'b1, 16'h00F0});
`else
    run_acc("sticky", 4'd3, 0, 0, {1'b1, 16'h00F1});
`endif

    run_acc("count0", 4'd0, 0, 5, {1'b0, 16'h0000});

    // Abort mid-run with reset; the next run must start clean.
    bus.start = 1'b1;
    bus.count = 4'd4;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b0;
      tick();
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h7777;
      tick();
    end
    bus.in_valid = 1'b0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("abort.in_ready", bus.in_ready, 0);
    check("abort.busy", bus.busy, 0);
    check("abort.out_valid", bus.out_valid, 0);
    check("abort.out_sum", bus.out_sum, 16'h0000);
    tick();
    beats[0] = 16'h0101;
    run_acc("after_abort", 4'd1, 0, 0, {1'b0, 16'h0101});

    for (int r = 0; r < 40; r++) begin
      logic [3:0] n;
      n = 4'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(3) == 0) beats[i] = {4{($urandom_range(1) != 0) ? 4'h7 : 4'h8}};
        else beats[i] = 16'($urandom);
      end
      exp = model(int'(n));
      run_acc("random", n, (r % 2 == 0) ? 0 : 35, int'($urandom_range(0, 3)), exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
